// File: rtl/framebuffer_writer.sv
// Render-side framebuffer write port: pixel FIFO, (x,y)->linear address,
// BRAM write driver, whole-frame clear and frame-completion pulse.
module framebuffer_writer #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned ADDR_BITS  = 17,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 pix_valid_in,
  output logic                 pix_ready_out,
  input  logic [8:0]           pix_x_in,
  input  logic [7:0]           pix_y_in,
  input  logic [3:0]           pix_shade_in,
  input  logic                 clear_req_in,
  input  logic [3:0]           clear_shade_in,
  output logic [ADDR_BITS-1:0] write_addr_out,
  output logic [3:0]           write_data_out,
  output logic                 write_en_out,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic                 drop_out
);

  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int unsigned NPIX     = WIDTH * HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
  localparam logic [PTR_BITS:0]    FULL_CNT  = (PTR_BITS + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [20:0]           mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_BITS:0]     count_q, count_d;
  logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
  logic [ADDR_BITS-1:0]  pix_cnt_q, pix_cnt_d;
  logic [3:0]            clr_shade_q, clr_shade_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [3:0]            data_q, data_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;

  logic                  push, pop, in_range;
  logic [20:0]           head;
  logic [ADDR_BITS-1:0]  head_x, head_y, head_addr;

  assign push      = pix_valid_in & ready_q;
  assign pop       = (state_q != CLEAR) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_x    = ADDR_BITS'(head[20:12]);
  assign head_y    = ADDR_BITS'(head[11:4]);
  assign in_range  = (head_x < ADDR_BITS'(WIDTH)) && (head_y < ADDR_BITS'(HEIGHT));
  assign head_addr = head_y * ADDR_BITS'(WIDTH) + head_x;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clr_addr_d  = clr_addr_q;
    pix_cnt_d   = pix_cnt_q;
    clr_shade_d = clr_shade_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    drop_d      = 1'b0;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    if (pop) begin
      if (in_range) begin
        we_d   = 1'b1;
        addr_d = head_addr;
        data_d = head[3:0];
        if (pix_cnt_q == LAST_ADDR) begin
          pix_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end else begin
        drop_d = 1'b1;
      end
    end

    unique case (state_q)
      RUN: begin
        if (clear_req_in) begin
          state_d     = DRAIN;
          clr_shade_d = clear_shade_in;
        end
      end
      DRAIN: begin
        // Leave on the edge that pops the last entry so the clear follows back-to-back.
        if (count_d == '0) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = clr_addr_q;
        data_d = clr_shade_q;
        if (clr_addr_q == LAST_ADDR) begin
          state_d   = RUN;
          pix_cnt_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    ready_d = (state_d == RUN) && (count_d != FULL_CNT);
    // Stays high while the final clear write is on the outputs.
    busy_d  = (state_d != RUN) || (state_q == CLEAR);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= RUN;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      clr_addr_q  <= '0;
      pix_cnt_q   <= '0;
      clr_shade_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      clr_addr_q  <= clr_addr_d;
      pix_cnt_q   <= pix_cnt_d;
      clr_shade_q <= clr_shade_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {pix_x_in, pix_y_in, pix_shade_in};
  end

  assign pix_ready_out  = ready_q;
  assign busy_out       = busy_q;
  assign write_en_out   = we_q;
  assign write_addr_out = addr_q;
  assign write_data_out = data_q;
  assign frame_done_out = done_q;
  assign drop_out       = drop_q;

endmodule
